// File: rtl/div_unit_seq.sv
// Iterative restoring divider (one quotient bit per cycle) for DIVU/DIV.
// Optional signed support is compiled in with `define SIGNED_DIV_EN.
module div_unit_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d, dvd_q, dvd_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next, quo_next, q_final, r_final;
  logic             unused_trial_msb;

`ifdef SIGNED_DIV_EN
  logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic sign_a, sign_b;

  always_comb begin
    sign_a = Signed & DataA[WIDTH-1];
    sign_b = Signed & DataB[WIDTH-1];
    abs_a  = sign_a ? -DataA : DataA;
    abs_b  = sign_b ? -DataB : DataB;
  end
`else
  logic unused_signed;
  assign unused_signed = Signed;
  assign abs_a = DataA;
  assign abs_b = DataB;
`endif

  // Subtract by invert-and-carry-in over WIDTH+1 bits; carry-out set means no borrow.
  assign rem_sh           = {rem_q, quo_q[WIDTH-1]};
  assign trial            = {1'b0, rem_sh} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH+2)'(1);
  assign no_borrow        = trial[WIDTH+1];
  assign unused_trial_msb = trial[WIDTH];
  assign rem_next         = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_next         = {quo_q[WIDTH-2:0], no_borrow};

`ifdef SIGNED_DIV_EN
  assign q_final = neg_quo_q ? -quo_next : quo_next;
  assign r_final = neg_rem_q ? -rem_next : rem_next;
`else
  assign q_final = quo_next;
  assign r_final = rem_next;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef SIGNED_DIV_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start) begin
          dbz_d = 1'b0;
          dvd_d = DataA;
          dvs_d = abs_b;
`ifdef SIGNED_DIV_EN
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
`endif
          if (DataB == '0) begin
            state_d = ZERO;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(WIDTH);
            rem_d   = '0;
            quo_d   = abs_a;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quotient_d  = q_final;
          remainder_d = r_final;
          state_d     = DONE;
        end
      end
      ZERO: begin
        quotient_d  = '1;
        remainder_d = dvd_q;
        dbz_d       = 1'b1;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef SIGNED_DIV_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign Busy      = (state_q == CALC) || (state_q == ZERO);
  assign Done      = (state_q == DONE);
  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Scoreboard bench for div_unit_seq: stimulus pushes model results, monitor pops on Done.
module tb_div_unit_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         Start, Signed;
  logic [W-1:0] DataA, DataB;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] Quotient, Remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int unsigned  due;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  bit          have_last = 0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  div_unit_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Signed(Signed),
    .DataA(DataA), .DataB(DataB), .Busy(Busy), .Done(Done),
    .Quotient(Quotient), .Remainder(Remainder), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sbv, qq, rr;
    e.due = 0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
    end else begin
      e.z = 1'b0;
      e.q = a / b;
      e.r = a % b;
`ifdef SIGNED_DIV_EN
      if (s) begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        qq  = sa / sbv;
        rr  = sa % sbv;
        e.q = qq[W-1:0];
        e.r = rr[W-1:0];
      end
`else
      if (s) e.z = 1'b0;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a negedge; Start is accepted at the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e = model(a, b, s);
    DataA = a; DataB = b; Signed = s; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    DataA = $urandom; DataB = $urandom; Signed = 1'($urandom);
    e.due = cyc + ((b == 0) ? 1 : W);
    sb.push_back(e);
    chk("busy_after_start", {31'd0, Busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Done && n < budget);
    if (!Done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no Done within %0d cycles", budget);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (Done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_done: got Done with no divide outstanding");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (Quotient !== e.q || Remainder !== e.r || DivByZero !== e.z || cyc != e.due || Busy !== 1'b0) begin
            errors++;
            $display("FAIL result: got q=%h r=%h z=%b cyc=%0d busy=%b expected q=%h r=%h z=%b cyc=%0d busy=0",
                     Quotient, Remainder, DivByZero, cyc, Busy, e.q, e.r, e.z, e.due);
          end
          last = e; have_last = 1;
        end
      end else if (have_last) begin
        checks++;
        if (Quotient !== last.q || Remainder !== last.r || DivByZero !== (Busy ? 1'b0 : last.z)) begin
          errors++;
          $display("FAIL hold: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                   Quotient, Remainder, DivByZero, last.q, last.r, Busy ? 1'b0 : last.z);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; Start = 1'b0; Signed = 1'b0; DataA = '0; DataB = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_done", {31'd0, Done}, 32'd0);
    chk("reset_quo", Quotient, 32'd0);
    chk("reset_rem", Remainder, 32'd0);
    chk("reset_dbz", {31'd0, DivByZero}, 32'd0);
    last = '{q: '0, r: '0, z: 1'b0, due: 0}; have_last = 1;
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd100, 32'd7, 1'b0);   wait_done(W + 5);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0); wait_done(W + 5);
    issue(32'd5, 32'd9, 1'b0);     wait_done(W + 5);
    issue(32'h1234, 32'd0, 1'b0);  wait_done(5);

    // Start during Busy ignored; Start in the Done cycle accepted.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    Start = 1'b1; DataA = 32'd9; DataB = 32'd3;
    @(posedge clk); #1; Start = 1'b0;
    wait_done(W + 5);
    issue(32'd9, 32'd3, 1'b0);
    wait_done(W + 5);

    // Reset mid-divide aborts without Done.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0; #1;
    sb.delete();
    last = '{q: '0, r: '0, z: 1'b0, due: 0};
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_quo", Quotient, 32'd0);
    chk("abort_rem", Remainder, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 5) @(negedge clk);
    issue(32'd50, 32'd5, 1'b0); wait_done(W + 5);

    // -7 / 2 with Signed set: signed or unsigned result depending on build.
    @(negedge clk);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1); wait_done(W + 5);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done(W + 5);
    issue(32'hFFFF_FFF9, 32'd0, 1'b1); wait_done(5);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      case ($urandom_range(3))
        0: b = 32'($urandom_range(15));
        1: b = $urandom;
        2: b = a >> $urandom_range(31);
        default: b = 32'($urandom_range(1000));
      endcase
      if ($urandom_range(1) == 0) @(negedge clk);
      issue(a, b, 1'($urandom));
      wait_done(W + 5);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
